bin_to_bcd: RTL and testbench

Sequential binary-to-BCD converter using iterative shift-and-add-3 (double dabble), one bit per clock. Sits directly upstream of the four-digit multiplexed 7-segment display driver. It converts a counter or measurement value into the four BCD digits (units, tens, hundreds, thousands) that the display driver consumes. Results are held stable between conversions so the display never shows a partial value.

---
 rtl/bin_to_bcd_pkg.sv | 15 +
 rtl/bin_to_bcd_if.sv | 24 ++
 rtl/bin_to_bcd_add3.sv | 11 +
 rtl/bin_to_bcd.sv | 87 ++++++++
 tb/tb_bin_to_bcd.sv | 203 ++++++++++++++++++++
 5 files changed

// File: rtl/bin_to_bcd_pkg.sv
// Shared constants and types for the sequential binary-to-BCD converter.
package bin_to_bcd_pkg;

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_CONVERT = 1'b1
    } state_t;

    localparam int          BCD_DIGITS = 4;
    localparam int          BCD_MAX    = 9999;
    localparam logic [15:0] BCD_SAT    = 16'h9999;
    localparam logic [3:0]  ADJ_THRESH = 4'd5;
    localparam logic [3:0]  ADJ_CONST  = 4'd3;

endpackage

// File: rtl/bin_to_bcd_if.sv
// Request/result bundle between the value source, the converter and the display driver.
interface bin_to_bcd_if #(
    parameter int BIN_WIDTH = 14
);
    logic                 start;
    logic [BIN_WIDTH-1:0] bin;
    logic                 busy;
    logic                 done;
    logic                 ovf;
    logic [3:0]           units;
    logic [3:0]           tens;
    logic [3:0]           hundreds;
    logic [3:0]           thousands;

    modport master (
        output start, bin,
        input  busy, done, ovf, units, tens, hundreds, thousands
    );

    modport slave (
        input  start, bin,
        output busy, done, ovf, units, tens, hundreds, thousands
    );
endinterface

// File: rtl/bin_to_bcd_add3.sv
// Double-dabble nibble correction: digits 5..9 become 8..12 so the next shift carries.
module bcd_add3
    import bin_to_bcd_pkg::*;
(
    input  logic [3:0] i_nib,
    output logic [3:0] o_nib
);

    assign o_nib = (i_nib >= ADJ_THRESH) ? i_nib + ADJ_CONST : i_nib;

endmodule

// File: rtl/bin_to_bcd.sv
// Iterative binary-to-BCD converter, one input bit per clock; results held between
// conversions so the display never sees a partial value.
module bin_to_bcd
    import bin_to_bcd_pkg::*;
#(
    parameter int BIN_WIDTH = 14
)(
    input  logic         i_clk,
    input  logic         i_rst,
    bin_to_bcd_if.slave  bus
);

    localparam logic [3:0] CNT_INIT = 4'(BIN_WIDTH);

    state_t                 r_state;
    logic [BIN_WIDTH-1:0]   r_shift;
    logic [15:0]            r_scratch;
    logic [3:0]             r_cnt;
    logic                   r_ovf_pend;
    logic                   r_busy;
    logic                   r_done;
    logic                   r_ovf;
    logic [15:0]            r_digits;

    logic [15:0]            w_adj;
    logic [BIN_WIDTH+15:0]  w_cat;
    logic                   w_ovf_in;

    for (genvar g = 0; g < BCD_DIGITS; g++) begin : g_adj
        bcd_add3 u_add3 (
            .i_nib (r_scratch[4*g +: 4]),
            .o_nib (w_adj[4*g +: 4])
        );
    end

    // Adjusted scratch and remaining input bits move left together as one register.
    assign w_cat    = {w_adj, r_shift} << 1;
    assign w_ovf_in = {{(32-BIN_WIDTH){1'b0}}, bus.bin} > 32'(BCD_MAX);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state    <= ST_IDLE;
            r_shift    <= '0;
            r_scratch  <= '0;
            r_cnt      <= '0;
            r_ovf_pend <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_ovf      <= 1'b0;
            r_digits   <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (bus.start) begin
                        r_shift    <= bus.bin;
                        r_scratch  <= '0;
                        r_cnt      <= CNT_INIT;
                        r_ovf_pend <= w_ovf_in;
                        r_busy     <= 1'b1;
                        r_state    <= ST_CONVERT;
                    end
                end
                ST_CONVERT: begin
                    {r_scratch, r_shift} <= w_cat;
                    r_cnt                <= r_cnt - 4'd1;
                    if (r_cnt == 4'd1) begin
                        r_digits <= r_ovf_pend ? BCD_SAT : w_cat[BIN_WIDTH +: 16];
                        r_ovf    <= r_ovf_pend;
                        r_done   <= 1'b1;
                        r_busy   <= 1'b0;
                        r_state  <= ST_IDLE;
                    end
                end
            endcase
        end
    end

    assign bus.busy      = r_busy;
    assign bus.done      = r_done;
    assign bus.ovf       = r_ovf;
    assign bus.units     = r_digits[3:0];
    assign bus.tens      = r_digits[7:4];
    assign bus.hundreds  = r_digits[11:8];
    assign bus.thousands = r_digits[15:12];

endmodule

// File: tb/tb_bin_to_bcd.sv
// Bench for bin_to_bcd: cycle-level decimal model checked every cycle, plus literal checks.
module tb_bin_to_bcd;

    localparam int BW = 14;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    bin_to_bcd_if #(.BIN_WIDTH(BW)) bus ();

    bin_to_bcd #(.BIN_WIDTH(BW)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;

    // Model: a conversion takes BW clocks after acceptance; value saturates above 9999.
    bit          armed = 1'b0;
    int          m_rem = 0;
    int          m_val = 0;
    logic [BW-1:0] m_pend = '0;
    logic        m_busy = 1'b0, m_done = 1'b0, m_ovf = 1'b0;

    always @(posedge clk) begin
        cyc++;
        armed = 1'b1;
        if (rst) begin
            m_rem = 0; m_busy = 0; m_done = 0; m_ovf = 0; m_val = 0;
        end else begin
            m_done = 1'b0;
            if (m_rem == 0) begin
                if (bus.start) begin
                    m_rem  = BW;
                    m_pend = bus.bin;
                    m_busy = 1'b1;
                end
            end else begin
                m_rem--;
                if (m_rem == 0) begin
                    m_busy = 1'b0;
                    m_done = 1'b1;
                    m_ovf  = int'(m_pend) > 9999;
                    m_val  = m_ovf ? 9999 : int'(m_pend);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (armed) begin
            vectors++;
            if (bus.busy !== m_busy || bus.done !== m_done || bus.ovf !== m_ovf ||
                bus.thousands !== 4'(m_val / 1000) || bus.hundreds !== 4'((m_val / 100) % 10) ||
                bus.tens !== 4'((m_val / 10) % 10) || bus.units !== 4'(m_val % 10)) begin
                miscompares++;
                $display("FAIL model cyc=%0d got busy=%0b done=%0b ovf=%0b digits=%0d%0d%0d%0d want busy=%0b done=%0b ovf=%0b value=%0d",
                         cyc, bus.busy, bus.done, bus.ovf, bus.thousands, bus.hundreds, bus.tens,
                         bus.units, m_busy, m_done, m_ovf, m_val);
            end
        end
    end

    task automatic chk(input string name, input int th, input int hu, input int te,
                       input int un, input logic ovf);
        vectors++;
        if (bus.thousands !== 4'(th) || bus.hundreds !== 4'(hu) || bus.tens !== 4'(te) ||
            bus.units !== 4'(un) || bus.ovf !== ovf) begin
            miscompares++;
            $display("FAIL %s got %0d,%0d,%0d,%0d ovf=%0b want %0d,%0d,%0d,%0d ovf=%0b", name,
                     bus.thousands, bus.hundreds, bus.tens, bus.units, bus.ovf, th, hu, te, un, ovf);
        end
    endtask

    task automatic chk_int(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s got %0d want %0d", name, act, exp);
        end
    endtask

    // Pulse START for one cycle; returns the cycle number of the accepting edge.
    task automatic go(input int val, output int t0);
        @(negedge clk);
        bus.start = 1'b1;
        bus.bin   = BW'(val);
        @(negedge clk);
        bus.start = 1'b0;
        t0 = cyc;
    endtask

    task automatic wait_done(output int c);
        c = -1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.done === 1'b1) begin
                c = cyc;
                break;
            end
        end
        if (c < 0) begin
            vectors++;
            miscompares++;
            $display("FAIL done_timeout cyc=%0d got no DONE want DONE within 40 cycles", cyc);
        end
    endtask

    initial begin
        int t0, d1, d2, ndone;
        rst       = 1'b1;
        bus.start = 1'b0;
        bus.bin   = '0;
        repeat (2) @(negedge clk);
        chk("reset_digits", 0, 0, 0, 0, 1'b0);
        chk_int("reset_busy", int'(bus.busy), 0);
        chk_int("reset_done", int'(bus.done), 0);
        rst = 1'b0;

        go(0, t0);
        wait_done(d1);
        chk("zero", 0, 0, 0, 0, 1'b0);
        chk_int("latency", d1 - t0, 14);

        go(1234, t0);
        wait_done(d1);
        chk("v1234", 1, 2, 3, 4, 1'b0);
        repeat (5) @(negedge clk);
        chk("v1234_held", 1, 2, 3, 4, 1'b0);

        go(9999, t0);  wait_done(d1); chk("v9999", 9, 9, 9, 9, 1'b0);
        go(10000, t0); wait_done(d1); chk("v10000", 9, 9, 9, 9, 1'b1);
        go(16383, t0); wait_done(d1); chk("v16383", 9, 9, 9, 9, 1'b1);

        // Start while busy and input wiggle are both ignored.
        go(42, t0);
        @(negedge clk);
        bus.start = 1'b1; bus.bin = BW'(7);
        @(negedge clk);
        bus.start = 1'b0;
        repeat (2) @(negedge clk);
        bus.bin = BW'(3210);
        wait_done(d1);
        chk("v42", 0, 0, 4, 2, 1'b0);
        ndone = 0;
        repeat (20) begin
            @(negedge clk);
            if (bus.done === 1'b1) ndone++;
        end
        chk_int("no_queued_start", ndone, 0);

        // Reset mid-conversion aborts with no result.
        go(8765, t0);
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_digits", 0, 0, 0, 0, 1'b0);
        chk_int("abort_busy", int'(bus.busy), 0);
        ndone = 0;
        repeat (16) begin
            @(negedge clk);
            if (bus.done === 1'b1) ndone++;
        end
        chk_int("abort_no_done", ndone, 0);
        go(305, t0); wait_done(d1); chk("v305", 0, 3, 0, 5, 1'b0);

        // Back-to-back with START held high.
        @(negedge clk);
        bus.start = 1'b1;
        bus.bin   = BW'(56);
        wait_done(d1);
        chk("b2b_56", 0, 0, 5, 6, 1'b0);
        bus.bin = BW'(789);
        @(negedge clk);
        bus.start = 1'b0;
        wait_done(d2);
        chk("b2b_789", 0, 7, 8, 9, 1'b0);
        chk_int("b2b_spacing", d2 - d1, 15);

        // Random values with random start/bin noise while busy; model checks every cycle.
        for (int i = 0; i < 150; i++) begin
            go(int'($urandom_range(0, 16383)), t0);
            repeat ($urandom_range(0, 10)) begin
                @(negedge clk);
                bus.start = 1'($urandom);
                bus.bin   = BW'($urandom);
            end
            @(negedge clk);
            bus.start = 1'b0;
            wait_done(d1);
        end
        repeat (3) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
